// File: rtl/fir_out_collector_if.sv
// Output stream bundle for fir_out_collector: sample, valid/ready handshake and last flag.
interface fir_out_collector_if #(
  parameter int unsigned OUT_W = 8
) ();
  logic [OUT_W-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/fir_out_collector.sv
// Sweeps FIR output addresses 0..7, scales each result and streams it through a small FIFO.
// Optional FIR_OUT_SAT_CNT_EN adds a per-sweep saturation counter output (sat_cnt).
module fir_out_collector #(
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned SHIFT   = 2,
  parameter int unsigned FIR_LAT = 1,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic [2:0]                fir_addr,
  input  logic [17:0]               fir_data,
  fir_out_collector_if.master       m_if,
  output logic                      busy,
  output logic                      done
`ifdef FIR_OUT_SAT_CNT_EN
  ,
  output logic [3:0]                sat_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StSweep = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  localparam logic [18:0] Rnd    = (19'd1 << SHIFT) >> 1;
  localparam logic [18:0] MaxOut = (19'd1 << OUT_W) - 19'd1;

  logic [1:0]                      state_q, state_d;
  logic [2:0]                      fir_addr_q, fir_addr_d;
  logic [2:0]                      next_idx_q, next_idx_d;
  logic [FIR_LAT-1:0]              pipe_v_q, pipe_v_d;
  logic [FIR_LAT-1:0][2:0]         pipe_tag_q, pipe_tag_d;
  logic [DEPTH-1:0][OUT_W:0]       mem_q, mem_d;
  logic [AW-1:0]                   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]                   rd_ptr_q, rd_ptr_d;
  logic [AW:0]                     count_q, count_d;

  logic [AW:0]      inflight;
  logic [AW:0]      free_slots;
  logic             start_acc;
  logic             issue;
  logic [2:0]       issue_idx;
  logic             capture;
  logic [2:0]       cap_tag;
  logic [18:0]      sum;
  logic [18:0]      shifted;
  logic             sat;
  logic [OUT_W-1:0] scaled;
  logic             push;
  logic             pop;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(FIR_LAT); i++) begin
      inflight = inflight + (AW+1)'(pipe_v_q[i]);
    end
    free_slots = (AW+1)'(DEPTH) - count_q;
    start_acc  = (state_q == StIdle) && start;
    issue_idx  = start_acc ? 3'd0 : next_idx_q;
    // A slot is reserved for every address in flight, so capture never meets a full FIFO.
    issue      = (free_slots > inflight) && (start_acc || (state_q == StSweep));
    capture    = pipe_v_q[FIR_LAT-1];
    cap_tag    = pipe_tag_q[FIR_LAT-1];
    done       = capture && (cap_tag == 3'd7);

    sum     = {1'b0, fir_data} + Rnd;
    shifted = sum >> SHIFT;
    sat     = shifted > MaxOut;
    scaled  = sat ? MaxOut[OUT_W-1:0] : shifted[OUT_W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    next_idx_d = next_idx_q;
    fir_addr_d = fir_addr_q;
    if (start_acc) begin
      state_d    = StSweep;
      next_idx_d = 3'd0;
    end
    if (issue) begin
      fir_addr_d = issue_idx;
      if (issue_idx == 3'd7) begin
        state_d = StDrain;
      end else begin
        next_idx_d = issue_idx + 3'd1;
      end
    end
    if ((state_q == StDrain) && done) begin
      state_d = StIdle;
    end

    pipe_v_d      = pipe_v_q;
    pipe_tag_d    = pipe_tag_q;
    pipe_v_d[0]   = issue;
    pipe_tag_d[0] = issue_idx;
    for (int i = 1; i < int'(FIR_LAT); i++) begin
      pipe_v_d[i]   = pipe_v_q[i-1];
      pipe_tag_d[i] = pipe_tag_q[i-1];
    end
  end

  always_comb begin
    push     = capture;
    pop      = m_if.m_valid && m_if.m_ready;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = {(cap_tag == 3'd7), scaled};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      fir_addr_q <= 3'd0;
      next_idx_q <= 3'd0;
      pipe_v_q   <= '0;
      pipe_tag_q <= '0;
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fir_addr_q <= fir_addr_d;
      next_idx_q <= next_idx_d;
      pipe_v_q   <= pipe_v_d;
      pipe_tag_q <= pipe_tag_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  assign fir_addr     = fir_addr_q;
  assign busy         = (state_q != StIdle);
  assign m_if.m_valid = (count_q != '0);
  assign m_if.m_data  = mem_q[rd_ptr_q][OUT_W-1:0];
  assign m_if.m_last  = mem_q[rd_ptr_q][OUT_W];

`ifdef FIR_OUT_SAT_CNT_EN
  logic [3:0] sat_cnt_q, sat_cnt_d;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (start_acc) begin
      sat_cnt_d = 4'd0;
    end else if (capture && sat && (sat_cnt_q != 4'd15)) begin
      sat_cnt_d = sat_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_q <= 4'd0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_fir_out_collector.sv
// Scoreboard bench for fir_out_collector: expected samples queued at start, checked on handshake.
module tb_fir_out_collector;
  localparam int unsigned OUT_W   = 8;
  localparam int unsigned SHIFT   = 2;
  localparam int unsigned FIR_LAT = 1;
  localparam int unsigned DEPTH   = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  fir_addr;
  logic [17:0] fir_data;
  logic        busy;
  logic        done;
`ifdef FIR_OUT_SAT_CNT_EN
  logic [3:0]  sat_cnt;
`endif

  logic [17:0]    rom [8];
  logic [OUT_W:0] exp_q [$];
  logic [OUT_W:0] stall_val;
  logic           stall_q = 1'b0;
  int             n_checks = 0;
  int             n_fail   = 0;
  int             rx_cnt   = 0;
  int             done_cnt = 0;

  fir_out_collector_if #(.OUT_W(OUT_W)) m_if ();

  fir_out_collector #(
    .OUT_W  (OUT_W),
    .SHIFT  (SHIFT),
    .FIR_LAT(FIR_LAT),
    .DEPTH  (DEPTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .fir_addr(fir_addr),
    .fir_data(fir_data),
    .m_if    (m_if),
    .busy    (busy),
    .done    (done)
`ifdef FIR_OUT_SAT_CNT_EN
    ,
    .sat_cnt (sat_cnt)
`endif
  );

  // One-cycle FIR latency: data follows the address within the same cycle.
  assign fir_data = rom[fir_addr];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] model_scale(input logic [17:0] d);
    int unsigned r;
    int unsigned mx;
    r  = (32'(d) + ((32'd1 << SHIFT) >> 1)) >> SHIFT;
    mx = (32'd1 << OUT_W) - 1;
    if (r > mx) r = mx;
    return OUT_W'(r);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_if.m_valid && m_if.m_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_sample", 32'd1, 32'd0);
        end else begin
          logic [OUT_W:0] e;
          e = exp_q.pop_front();
          check("m_data", 32'(m_if.m_data), 32'(e[OUT_W-1:0]));
          check("m_last", 32'(m_if.m_last), 32'(e[OUT_W]));
          rx_cnt++;
        end
      end
      if (stall_q && m_if.m_valid) begin
        check("stall_stable", 32'({m_if.m_last, m_if.m_data}), 32'(stall_val));
      end
      stall_q   = m_if.m_valid && !m_if.m_ready;
      stall_val = {m_if.m_last, m_if.m_data};
      if (done) done_cnt++;
    end else begin
      stall_q = 1'b0;
    end
  end

  task automatic start_sweep();
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({(i == 7), model_scale(rom[i])});
    end
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) break;
    end
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    m_if.m_ready = 1'b0;
    for (int i = 0; i < 8; i++) rom[i] = '0;
    #12;
    check("rst_m_valid", 32'(m_if.m_valid), 32'd0);
    check("rst_m_data", 32'(m_if.m_data), 32'd0);
    check("rst_m_last", 32'(m_if.m_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fir_addr", 32'(fir_addr), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Zero data
    m_if.m_ready = 1'b1;
    rx_cnt = 0; done_cnt = 0;
    start_sweep();
    wait_idle("zero");
    check("zero_rx_cnt", 32'(rx_cnt), 32'd8);
    check("zero_done_cnt", 32'(done_cnt), 32'd1);

    // Impulse response, addresses on consecutive cycles
    rom[0] = 4; rom[1] = 8; rom[2] = 12; rom[3] = 16;
    rom[4] = 12; rom[5] = 8; rom[6] = 4; rom[7] = 4;
    rx_cnt = 0;
    start_sweep();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("fir_addr_step", 32'(fir_addr), 32'(i));
    end
    wait_idle("impulse");
    check("impulse_rx_cnt", 32'(rx_cnt), 32'd8);

    // Rounding and saturation
    rom[0] = 6; rom[1] = 5; rom[2] = 1022; rom[3] = 262143;
    for (int i = 4; i < 8; i++) rom[i] = 18'(i * 7);
    start_sweep();
    wait_idle("round");
`ifdef FIR_OUT_SAT_CNT_EN
    check("sat_cnt_two", 32'(sat_cnt), 32'd2);
`endif
    for (int i = 0; i < 8; i++) rom[i] = 18'(i * 40);
    rom[5] = 262143;
    start_sweep();
    wait_idle("sat_one");
`ifdef FIR_OUT_SAT_CNT_EN
    check("sat_cnt_one", 32'(sat_cnt), 32'd1);
`endif

    // Backpressure for the whole sweep
    for (int i = 0; i < 8; i++) rom[i] = 18'(i * 100 + 3);
    m_if.m_ready = 1'b0;
    rx_cnt = 0;
    start_sweep();
    repeat (20) @(negedge clk);
    check("bp_m_valid", 32'(m_if.m_valid), 32'd1);
    check("bp_fir_addr_frozen", 32'(fir_addr), 32'(DEPTH - 1));
    check("bp_busy", 32'(busy), 32'd1);
    check("bp_rx_cnt", 32'(rx_cnt), 32'd0);
    @(posedge clk); #1 m_if.m_ready = 1'b1;
    wait_idle("bp");
    check("bp_rx_total", 32'(rx_cnt), 32'd8);

    // Reset mid-sweep
    rx_cnt = 0;
    start_sweep();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rx_cnt >= 3) break;
    end
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_m_valid", 32'(m_if.m_valid), 32'd0);
    check("mid_rst_m_data", 32'(m_if.m_data), 32'd0);
    check("mid_rst_m_last", 32'(m_if.m_last), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_fir_addr", 32'(fir_addr), 32'd0);
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;

    // Clean sweep after reset, with a start pulsed while busy
    rx_cnt = 0; done_cnt = 0;
    start_sweep();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle("post_rst");
    repeat (5) @(negedge clk);
    check("post_rst_rx_cnt", 32'(rx_cnt), 32'd8);
    check("post_rst_done_cnt", 32'(done_cnt), 32'd1);

    // Start coincident with done is ignored
    rx_cnt = 0;
    start_sweep();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) break;
    end
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("done_start_busy", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    check("done_start_rx_cnt", 32'(rx_cnt), 32'd8);
    check("done_start_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/fir_out_collector.md
Name: fir_out_collector

Overview:
- Downstream stage of the FIR block.
- After each coefficient load, it sweeps the FIR output address 0..7 and captures the 18-bit filtered result for each address.
- Each result is rounded, right-shifted and saturated to OUT_W bits, then streamed out through a small FIFO with a valid/ready handshake.
- Backpressure stalls the sweep; no result is ever dropped.

Parameters:
- OUT_W, 8: width of streamed output samples (1..18).
- SHIFT, 2: right-shift applied to fir_data, with round-half-up (0..17).
- FIR_LAT, 1: cycles from fir_addr change to matching fir_data (1..3).
- DEPTH, 4: output FIFO entries; power of 2, must be >= FIR_LAT+1.

Ports:
- clk, input, 1: single clock, rising-edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: one-cycle pulse that launches a sweep; issue it the cycle after the FIR write is deasserted.
- fir_addr, output, 3: address driven to the FIR block.
- fir_data, input, 18: FIR output, unsigned.
- m_data, output, OUT_W: scaled sample at FIFO head.
- m_valid, output, 1: m_data is valid.
- m_ready, input, 1: consumer accepts.
- m_last, output, 1: high with the sample from address 7.
- busy, output, 1: sweep or capture in progress.
- done, output, 1: one-cycle pulse when the address-7 sample is written into the FIFO.

Behaviour:
- Reset (async assert, sync release): state IDLE; fir_addr=0; FIFO empty; m_valid=0; m_data=0; m_last=0; busy=0; done=0.
- Reset asserted mid-sweep discards in-flight captures and all FIFO contents.
- IDLE:
  - start=1 -> SWEEP, issue index 0, busy=1.
  - start while busy is ignored.
- SWEEP issue rule:
  - An address k is issued (fir_addr<=k) in a cycle only if free_slots > inflight.
  - inflight = addresses issued but not yet captured (max FIR_LAT).
  - Otherwise fir_addr holds its value and nothing is issued.
  - After issuing index 7 -> DRAIN.
- Capture:
  - A FIR_LAT-deep valid pipeline tags each issued address.
  - When the tag exits, fir_data is sampled and the scaled value is pushed with last=(tag==7).
  - Capture never stalls, because issue reserved the slot.
- DRAIN:
  - When the index-7 capture is pushed: pulse done, -> IDLE, busy=0 the following cycle.
  - fir_addr stays at 7 until the next start.
- Scaling:
  - r = (fir_data + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >> SHIFT, computed in 19 bits so the add never wraps.
  - m_data = (r > 2^OUT_W-1) ? 2^OUT_W-1 : r[OUT_W-1:0].
- FIFO:
  - Push and pop in the same cycle are allowed, including when full.
  - m_valid = !empty.
  - m_data and m_last are registered from the head; they are stable while m_valid=1 and m_ready=0.
- Ordering: output order is always address 0..7. Exactly 8 samples per start; m_last is high on the 8th only.
- A start arriving in the same cycle as done is ignored; the next start is accepted from the cycle after.

Optional Feature:
- Macro FIR_OUT_SAT_CNT_EN.
- Defined:
  - Adds output port sat_cnt, 4 bits.
  - Counts samples clipped by saturation in the current sweep, saturating at 15.
  - Cleared when start is accepted; holds after done until the next start.
  - Reset value 0.
- Undefined: no port and no counter logic. Saturation itself is unchanged.

Test Plan:
- Zero data: start with fir_data=0 at all addresses, m_ready=1 -> 8 samples of 0; m_last on the 8th only; done pulses once; busy low afterwards.
- Impulse response:
  - Bench FIR model returns {4,8,12,16,12,8,4,4} with FIR_LAT=1, SHIFT=2.
  - Expect m_data {1,2,3,4,3,2,1,1} in order; fir_addr steps 0..7 on consecutive cycles.
- Rounding/saturation, OUT_W=8, SHIFT=2:
  - fir_data 6 -> 2; 5 -> 1; 1022 -> 255; 262143 -> 255.
  - With FIR_OUT_SAT_CNT_EN: sat_cnt=1 when only 262143 is applied; sat_cnt=2 when both 1022 and 262143 are applied.
- Backpressure:
  - m_ready=0 for the whole sweep -> sweep stalls with exactly DEPTH=4 samples queued, fir_addr frozen, no loss.
  - Then raise m_ready -> all 8 samples arrive in order, m_data stable during the stall.
- Reset and start corner cases:
  - Assert rst_n=0 after 3 samples -> all outputs return to reset values immediately.
  - A new start then yields a clean 8-sample sweep.
  - A start pulsed while busy=1 produces no extra samples.
